// File: rtl/branch_predictor_cp.sv
// rtl/branch_predictor_cp.sv - direct-mapped BTB/BHT branch predictor with stage-3 redirect
// Optional BP_PERF_CNT_EN adds resolution and mispredict counters.
module branch_predictor_cp #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic [XLEN-1:0] pc_s1_i,
  output logic            pred_taken_s1_o,
  output logic [XLEN-1:0] pred_pc_s1_o,
  input  logic            branch_s3_i,
  input  logic            jump_s3_i,
  input  logic            pc_src_s3_i,
  input  logic [XLEN-1:0] pc_s3_i,
  input  logic [XLEN-1:0] target_s3_i,
  output logic            mispredict_s3_o,
  output logic [XLEN-1:0] redirect_pc_s3_o,
  output logic            flush_s1_o,
  output logic            flush_s2_o
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches_o,
  output logic [31:0]     perf_mispredicts_o
`endif
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  typedef struct packed {
    logic            valid;
    logic            taken;
    logic [XLEN-1:0] pred_pc;
  } pred_t;

  localparam pred_t BUBBLE = '{valid: 1'b0, taken: 1'b0, pred_pc: '0};

  logic             valid_q  [BTB_ENTRIES];
  logic [1:0]       ctr_q    [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]  target_q [BTB_ENTRIES];

  pred_t pred_s2_q, pred_s3_q;

  logic [IDX_W-1:0] idx_s1, idx_s3;
  logic [TAG_W-1:0] tag_s1, tag_s3;
  logic             hit_s1, hit_s3;
  logic             active_s3, taken_s3, mispredict;
  logic [1:0]       ctr_nxt;

  assign idx_s1 = pc_s1_i[IDX_W+1:2];
  assign tag_s1 = pc_s1_i[XLEN-1:IDX_W+2];
  assign idx_s3 = pc_s3_i[IDX_W+1:2];
  assign tag_s3 = pc_s3_i[XLEN-1:IDX_W+2];

  // Stage-1 lookup reads the pre-update table, so same-index writes show up next cycle.
  assign hit_s1          = valid_q[idx_s1] && (tag_q[idx_s1] == tag_s1);
  assign pred_taken_s1_o = !rst_i && hit_s1 && ctr_q[idx_s1][1];
  assign pred_pc_s1_o    = pred_taken_s1_o ? target_q[idx_s1] : pc_s1_i + PC_INC;

  assign hit_s3    = valid_q[idx_s3] && (tag_q[idx_s3] == tag_s3);
  assign taken_s3  = pc_src_s3_i || jump_s3_i;
  assign active_s3 = !rst_i && (branch_s3_i || jump_s3_i) && pred_s3_q.valid;

  assign mispredict = active_s3 &&
                      ((pc_src_s3_i != pred_s3_q.taken) ||
                       (pc_src_s3_i && pred_s3_q.taken && (target_s3_i != pred_s3_q.pred_pc)));

  assign mispredict_s3_o  = mispredict;
  assign flush_s1_o       = mispredict;
  assign flush_s2_o       = mispredict;
  assign redirect_pc_s3_o = rst_i ? '0 : (pc_src_s3_i ? target_s3_i : pc_s3_i + PC_INC);

  always_comb begin
    ctr_nxt = ctr_q[idx_s3];
    if (taken_s3) begin
      if (ctr_q[idx_s3] != 2'b11) ctr_nxt = ctr_q[idx_s3] + 2'd1;
    end else begin
      if (ctr_q[idx_s3] != 2'b00) ctr_nxt = ctr_q[idx_s3] - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (active_s3) begin
      if (hit_s3) begin
        ctr_q[idx_s3] <= ctr_nxt;
      end else if (taken_s3) begin
        valid_q[idx_s3] <= 1'b1;
        ctr_q[idx_s3]   <= 2'b10;
      end
    end
  end

  // Tag and target carry no reset; valid alone gates their use.
  always_ff @(posedge clk_i) begin
    if (active_s3 && taken_s3) begin
      tag_q[idx_s3]    <= tag_s3;
      target_q[idx_s3] <= target_s3_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || mispredict) begin
      pred_s2_q <= BUBBLE;
      pred_s3_q <= BUBBLE;
    end else if (stall_i) begin
      pred_s3_q <= BUBBLE;
    end else begin
      pred_s2_q <= '{valid: 1'b1, taken: pred_taken_s1_o, pred_pc: pred_pc_s1_o};
      pred_s3_q <= pred_s2_q;
    end
  end

`ifdef BP_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_branches_o    <= '0;
      perf_mispredicts_o <= '0;
    end else begin
      if (active_s3)  perf_branches_o    <= perf_branches_o + 32'd1;
      if (mispredict) perf_mispredicts_o <= perf_mispredicts_o + 32'd1;
    end
  end
`endif

endmodule
